// File: rtl/mul_wb_queue_pkg.sv
// Shared core package: machine widths and the mul writeback entry layout.
package mul_wb_queue_pkg;

  localparam int M_WIDTH        = 64;
  localparam int LG_ROB_ENTRIES = 6;
  localparam int LG_PRF_ENTRIES = 7;
  localparam int MUL_LAT        = 3;

  typedef struct packed {
    logic [M_WIDTH-1:0]        y;
    logic [LG_ROB_ENTRIES-1:0] rob_ptr;
    logic                      prf_val;
    logic [LG_PRF_ENTRIES-1:0] prf_ptr;
  } mul_wb_entry_t;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = 6'd0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/mul_wb_queue_if.sv
// Mul-unit result and writeback handshake bundle for the mul writeback queue.
interface mul_wb_queue_if;
  import mul_wb_queue_pkg::*;

  logic                      mul_go;
  logic                      mul_can_issue;
  logic                      mul_complete;
  logic [M_WIDTH-1:0]        mul_y;
  logic [LG_ROB_ENTRIES-1:0] mul_rob_ptr;
  logic                      mul_prf_val;
  logic [LG_PRF_ENTRIES-1:0] mul_prf_ptr;
  logic                      wb_valid;
  logic                      wb_ready;
  logic [M_WIDTH-1:0]        wb_y;
  logic [LG_ROB_ENTRIES-1:0] wb_rob_ptr;
  logic                      wb_prf_val;
  logic [LG_PRF_ENTRIES-1:0] wb_prf_ptr;

  modport master (
    output mul_go, mul_complete, mul_y, mul_rob_ptr, mul_prf_val, mul_prf_ptr, wb_ready,
    input  mul_can_issue, wb_valid, wb_y, wb_rob_ptr, wb_prf_val, wb_prf_ptr
  );

  modport slave (
    input  mul_go, mul_complete, mul_y, mul_rob_ptr, mul_prf_val, mul_prf_ptr, wb_ready,
    output mul_can_issue, wb_valid, wb_y, wb_rob_ptr, wb_prf_val, wb_prf_ptr
  );

endinterface

// File: rtl/mul_wb_queue_chk.sv
// Simulation checks on the credit protocol around the mul writeback queue.
module mul_wb_queue_chk (
  input logic clk,
  input logic reset,
  input logic push,
  input logic full,
  input logic mul_go,
  input logic mul_can_issue
);

  // Both conditions mean issue logic ignored the credit signal.
  push_into_full: assert property (@(posedge clk) disable iff (reset) !(push && full))
    else $error("mul_wb_queue: push while buffer full");

  go_without_credit: assert property (@(posedge clk) disable iff (reset) !(mul_go && !mul_can_issue))
    else $error("mul_wb_queue: mul_go without credit");

endmodule

// File: rtl/mul_wb_queue_fifo.sv
// wb_fifo: circular result buffer with head/tail pointers and an occupancy count.
module wb_fifo
  import mul_wb_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  mul_wb_entry_t          push_data,
  output mul_wb_entry_t          head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [AW:0]   count_r;
  logic          push_ok_s;
  mul_wb_entry_t mem_r [DEPTH];

  // A push into a full buffer is only accepted when the head leaves in the same cycle.
  assign full      = (count_r == (AW+1)'(DEPTH));
  assign push_ok_s = push & (~full | pop);
  assign count     = count_r;
  assign head_data = mem_r[head_r];

  // Pointer and occupancy update; clear outranks push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (clear) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_ok_s) tail_r <= tail_r + AW'(1);
      if (pop)       head_r <= head_r + AW'(1);
      case ({push_ok_s, pop})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Data array write; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s & ~clear) mem_r[tail_r] <= push_data;
  end

endmodule

// File: rtl/mul_wb_queue.sv
// Mul writeback queue: credit-tracked buffer between the mul unit and the PRF writeback arbiter.
module mul_wb_queue
  import mul_wb_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LAT   = MUL_LAT + 1
) (
  input logic          clk,
  input logic          reset,
  input logic          flush,
  mul_wb_queue_if.slave bus
);

  logic [LAT-1:0]         shadow_r;
  logic [$clog2(DEPTH):0] count_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   full_s;
  logic                   wb_valid_s;
  logic [31:0]            used_s;
  mul_wb_entry_t          push_data_s;
  mul_wb_entry_t          head_data_s;

  // Only completions matched by a live shadow bit are real; stale ones from before a flush/reset drop.
  always_comb begin
    push_data_s = '{y: bus.mul_y, rob_ptr: bus.mul_rob_ptr,
                    prf_val: bus.mul_prf_val, prf_ptr: bus.mul_prf_ptr};
    push_s      = bus.mul_complete & shadow_r[LAT-1] & ~flush;
    wb_valid_s  = (count_s != '0);
    pop_s       = wb_valid_s & bus.wb_ready;
    used_s      = 32'(count_s) + 32'(popcount32(32'(shadow_r)));
  end

  // In-flight op tracker: one bit per outstanding mul, aligned to its completion cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_r <= '0;
    end else if (flush) begin
      shadow_r <= '0;
    end else begin
      shadow_r <= (shadow_r << 1) | LAT'(bus.mul_go);
    end
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (push_data_s),
    .head_data (head_data_s),
    .count     (count_s),
    .full      (full_s)
  );

  assign bus.mul_can_issue = (used_s < 32'(DEPTH));
  assign bus.wb_valid      = wb_valid_s;
  assign bus.wb_y          = head_data_s.y;
  assign bus.wb_rob_ptr    = head_data_s.rob_ptr;
  assign bus.wb_prf_val    = head_data_s.prf_val;
  assign bus.wb_prf_ptr    = head_data_s.prf_ptr;

  mul_wb_queue_chk u_chk (
    .clk           (clk),
    .reset         (reset),
    .push          (push_s),
    .full          (full_s),
    .mul_go        (bus.mul_go),
    .mul_can_issue (bus.mul_can_issue)
  );

endmodule

// File: tb/tb_mul_wb_queue.sv
// Scoreboard bench for mul_wb_queue: directed ops, monitor compares each accepted writeback.
module tb_mul_wb_queue;
  import mul_wb_queue_pkg::*;

  localparam int LAT = MUL_LAT + 1;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   n_checks = 0;
  int   n_fail   = 0;
  mul_wb_entry_t exp_q[$];

  mul_wb_queue_if bus_if();

  mul_wb_queue #(.DEPTH(4), .LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.mul_go       = 1'b0;
    bus_if.mul_complete = 1'b0;
    bus_if.mul_y        = '0;
    bus_if.mul_rob_ptr  = '0;
    bus_if.mul_prf_val  = 1'b0;
    bus_if.mul_prf_ptr  = '0;
    bus_if.wb_ready     = 1'b1;
    flush               = 1'b0;
  endtask

  task automatic idle(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive_complete(input logic [63:0] y, input int tag, input bit exp_push);
    mul_wb_entry_t e;
    bus_if.mul_complete = 1'b1;
    bus_if.mul_y        = y;
    bus_if.mul_rob_ptr  = LG_ROB_ENTRIES'(tag);
    bus_if.mul_prf_val  = tag[0];
    bus_if.mul_prf_ptr  = LG_PRF_ENTRIES'(tag + 3);
    if (exp_push) begin
      e.y       = y;
      e.rob_ptr = LG_ROB_ENTRIES'(tag);
      e.prf_val = tag[0];
      e.prf_ptr = LG_PRF_ENTRIES'(tag + 3);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every accepted writeback must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && bus_if.wb_valid && bus_if.wb_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wb", 64'(bus_if.wb_y), 64'hDEAD_0000_0000_DEAD);
      end else begin
        check("wb_y",       64'(bus_if.wb_y),       64'(exp_q[0].y));
        check("wb_rob_ptr", 64'(bus_if.wb_rob_ptr), 64'(exp_q[0].rob_ptr));
        check("wb_prf_val", 64'(bus_if.wb_prf_val), 64'(exp_q[0].prf_val));
        check("wb_prf_ptr", 64'(bus_if.wb_prf_ptr), 64'(exp_q[0].prf_ptr));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    #1;
    check("rst_wb_valid", 64'(bus_if.wb_valid), 64'd0);
    check("rst_can_issue", 64'(bus_if.mul_can_issue), 64'd1);
    step();
    step();
    reset = 1'b0;
    check("post_rst_wb_valid", 64'(bus_if.wb_valid), 64'd0);
    check("post_rst_can_issue", 64'(bus_if.mul_can_issue), 64'd1);
    idle(LAT + 1);

    // Single op: y=0x2A visible exactly in cycle LAT+1.
    for (int c = 0; c <= LAT + 2; c++) begin
      idle_inputs();
      bus_if.mul_go = (c == 0);
      if (c == LAT) drive_complete(64'h2A, 5, 1'b1);
      if (c >= 1 && c <= LAT) check("single_can_issue", 64'(bus_if.mul_can_issue), 64'd1);
      check("single_wb_valid", 64'(bus_if.wb_valid), (c == LAT + 1) ? 64'd1 : 64'd0);
      step();
    end
    idle(2);

    // Back-pressure: four ops fill the credits; release drains in order.
    for (int c = 0; c <= LAT + 8; c++) begin
      idle_inputs();
      bus_if.mul_go   = (c < 4);
      bus_if.wb_ready = (c >= LAT + 4);
      if (c >= LAT && c < LAT + 4) drive_complete(64'h100 + 64'(c - LAT), c, 1'b1);
      if (c >= LAT && c <= LAT + 4) check("bp_no_credit", 64'(bus_if.mul_can_issue), 64'd0);
      if (c == LAT + 4) check("bp_full_valid", 64'(bus_if.wb_valid), 64'd1);
      if (c == LAT + 5) check("bp_credit_back", 64'(bus_if.mul_can_issue), 64'd1);
      if (c == LAT + 8) check("bp_drained", 64'(bus_if.wb_valid), 64'd0);
      step();
    end
    idle(2);

    // Flush in flight: both later completions are stale and dropped.
    for (int c = 0; c <= LAT + 3; c++) begin
      idle_inputs();
      bus_if.mul_go = (c < 2);
      flush         = (c == 2);
      if (c == LAT || c == LAT + 1) drive_complete(64'h300 + 64'(c), c, 1'b0);
      check("flush_wb_valid", 64'(bus_if.wb_valid), 64'd0);
      if (c == 3) begin
        check("flush_shadow", 64'(dut.shadow_r), 64'd0);
        check("flush_count", 64'(dut.u_fifo.count_r), 64'd0);
        check("flush_can_issue", 64'(bus_if.mul_can_issue), 64'd1);
      end
      step();
    end
    check("flush_count_end", 64'(dut.u_fifo.count_r), 64'd0);
    idle(2);

    // Simultaneous push and pop at count=2 keeps the count at 2.
    for (int c = 0; c <= LAT + 6; c++) begin
      idle_inputs();
      bus_if.mul_go   = (c < 4);
      bus_if.wb_ready = (c >= LAT + 2);
      if (c >= LAT && c < LAT + 4) drive_complete(64'h400 + 64'(c - LAT), c + 8, 1'b1);
      if (c >= LAT + 2 && c <= LAT + 4) check("pp_count", 64'(dut.u_fifo.count_r), 64'd2);
      step();
    end
    idle(2);

    // Wrap: ten ops in pairs walk the pointers around the buffer several times.
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < LAT + 3; c++) begin
        idle_inputs();
        bus_if.mul_go = (c < 2);
        if (c == LAT || c == LAT + 1) drive_complete(64'h500 + 64'(2 * r + c - LAT), 2 * r + c - LAT + 20, 1'b1);
        step();
      end
    end
    check("wrap_drained", 64'(exp_q.size()), 64'd0);
    idle(2);

    // Reset mid-operation with three entries buffered and one op in flight.
    for (int c = 0; c < LAT + 3; c++) begin
      idle_inputs();
      bus_if.mul_go   = (c < 4);
      bus_if.wb_ready = 1'b0;
      if (c >= LAT && c < LAT + 3) drive_complete(64'h600 + 64'(c), c, 1'b1);
      step();
    end
    idle_inputs();
    bus_if.wb_ready = 1'b0;
    check("pre_rst_valid", 64'(bus_if.wb_valid), 64'd1);
    check("pre_rst_count", 64'(dut.u_fifo.count_r), 64'd3);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_valid", 64'(bus_if.wb_valid), 64'd0);
    check("async_rst_can_issue", 64'(bus_if.mul_can_issue), 64'd1);
    check("async_rst_shadow", 64'(dut.shadow_r), 64'd0);
    step();
    reset = 1'b0;
    bus_if.wb_ready = 1'b1;
    drive_complete(64'h6FF, 3, 1'b0);
    step();
    idle_inputs();
    check("rst_window_valid", 64'(bus_if.wb_valid), 64'd0);
    step();
    check("rst_window_valid2", 64'(bus_if.wb_valid), 64'd0);
    check("rst_window_can_issue", 64'(bus_if.mul_can_issue), 64'd1);
    idle(LAT + 1);

    // Unsolicited complete: nothing in flight, so nothing is pushed.
    drive_complete(64'h77, 7, 1'b0);
    step();
    idle_inputs();
    check("unsol_valid", 64'(bus_if.wb_valid), 64'd0);
    step();
    check("unsol_count", 64'(dut.u_fifo.count_r), 64'd0);
    idle(3);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_wb_queue.md
MUL_WB_QUEUE -- requirements
Module: mul_wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: result-buffer entries, power of 2, at least 2.
REQ-002 SHALL have parameter LAT, default `MUL_LAT+1: cycles from mul go to mul complete.
REQ-003 SHALL have port clk, input, 1 bit: the one clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1 bit: pipeline flush; discards buffered and in-flight results.
REQ-006 SHALL have port mul_go, input, 1 bit: a mul/fp op is issued to the mul unit this cycle.
REQ-007 SHALL have port mul_can_issue, output, 1 bit: a credit is available; issue logic may assert mul_go.
REQ-008 SHALL have port mul_complete, input, 1 bit: the mul unit result is valid.
REQ-009 SHALL have port mul_y, input, `M_WIDTH bits: the mul unit result.
REQ-010 SHALL have port mul_rob_ptr, input, `LG_ROB_ENTRIES bits: the result's ROB pointer.
REQ-011 SHALL have port mul_prf_val, input, 1 bit: the result writes the PRF.
REQ-012 SHALL have port mul_prf_ptr, input, `LG_PRF_ENTRIES bits: the destination PRF pointer.
REQ-013 SHALL have port wb_valid, output, 1 bit: the head entry is presented on the wb_* outputs.
REQ-014 SHALL have port wb_ready, input, 1 bit: the writeback arbiter accepts the head entry.
REQ-015 SHALL have outputs wb_y (`M_WIDTH bits), wb_rob_ptr (`LG_ROB_ENTRIES bits), wb_prf_val (1 bit) and wb_prf_ptr (`LG_PRF_ENTRIES bits): the head entry fields.

Function
REQ-016 SHALL keep a LAT-bit shadow shift register: bit 0 is loaded with (mul_go & ~flush); the register shifts every cycle.
REQ-017 SHALL push {mul_y, mul_rob_ptr, mul_prf_val, mul_prf_ptr} only when mul_complete & shadow[LAT-1] & ~flush.
REQ-018 SHALL silently drop a mul_complete that arrives while shadow[LAT-1] is 0; this covers ops issued before a flush.
REQ-019 SHALL compute mul_can_issue = (count + popcount(shadow)) < DEPTH; this is combinational, and a same-cycle pop earns no credit.
REQ-020 SHALL pop the head on wb_valid & wb_ready; wb_valid = (count != 0).
REQ-021 SHALL hold the wb_* outputs stable while wb_valid & ~wb_ready.
REQ-022 SHALL add no pass-through path: a pushed entry is first visible the cycle after the push; minimum latency is 1 cycle.
REQ-023 SHALL leave count unchanged on a simultaneous push and pop; the head and tail pointers advance independently.
REQ-024 SHALL wrap the head and tail pointers modulo DEPTH; count runs from 0 to DEPTH inclusive.
REQ-025 SHALL, on flush, clear count, head, tail and the shadow register next cycle; flush takes priority over a same-cycle push and pop.
REQ-026 SHALL flag, in simulation only, a push while count==DEPTH and mul_go while ~mul_can_issue as errors; these are unreachable with correct credits.
REQ-027 SHALL preserve FIFO order: writeback order equals mul completion order.

Reset
REQ-028 SHALL, on asynchronous reset assertion, clear count, head, tail and shadow immediately, without waiting for a clock edge.
REQ-029 SHALL have wb_valid=0 and mul_can_issue=1 while in reset and after reset.
REQ-030 SHALL leave the buffer data array unreset; its contents are don't-care while count==0.
REQ-031 SHALL drop any mul_complete arriving in the first LAT cycles after reset release, because shadow is 0.

Structure
REQ-032 SHALL place the mul_wb_entry_t typedef {y, rob_ptr, prf_val, prf_ptr} in the shared core package, sized from the machine.vh widths.
REQ-033 SHALL implement the storage as one sub-module, wb_fifo; the shadow register and credit logic stay in mul_wb_queue.
REQ-034 SHALL sit directly downstream of the mul unit, and its wb_* outputs SHALL feed the PRF writeback arbiter.

Verification
REQ-035 SHALL cover single op: mul_go at cycle 0, mul_complete at cycle LAT with y=0x2A, wb_ready=1 -> wb_valid exactly one cycle, at cycle LAT+1, with wb_y=0x2A.
REQ-036 SHALL cover back-pressure: 4 back-to-back ops with wb_ready=0 -> mul_can_issue=0 after 4 issues; releasing wb_ready -> 4 entries drain in order, and mul_can_issue=1 the cycle after the first pop.
REQ-037 SHALL cover flush in flight: mul_go at cycles 0-1, flush at cycle 2, complete at cycles LAT and LAT+1 -> both dropped, wb_valid stays 0, and count/shadow read 0.
REQ-038 SHALL cover simultaneous push and pop at count=2 -> count stays 2; the new entry lands at the tail and the head advances; wrap is exercised over 10 ops.
REQ-039 SHALL cover reset mid-operation: async reset with 3 entries buffered -> wb_valid=0 immediately and mul_can_issue=1; a complete arriving inside the LAT-cycle window after release is dropped.
REQ-040 SHALL cover unsolicited complete: mul_complete with no preceding mul_go -> no push, and no assertion fires.
